// File: rtl/cl_pcim_pkg.sv
// cl_pcim_pkg: shared state type and widths for the PCIM outstanding-transaction guard
package cl_pcim_pkg;
    typedef enum logic [1:0] {RUN, DRAIN, QUIESCED, HUNG} otr_state_e;
    localparam int CNT_W = 8;
    localparam int TIMEOUT_DEF = 65535;
    localparam int TMR_W = $clog2(TIMEOUT_DEF + 1);
    function automatic int tmr_w(input int t);
        return $clog2(t + 1);
    endfunction
endpackage

// File: rtl/cl_pcim_otr_ctr.sv
// cl_pcim_otr_ctr: outstanding count, response-progress timer and unexpected-response flag for one direction
module cl_pcim_otr_ctr
    import cl_pcim_pkg::*;
#(
    parameter int MAX = 16,
    parameter int TIMEOUT = 65535
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] cnt,
    output logic             room,
    output logic             zero_nxt,
    output logic             tmo,
    output logic             unexp
);
    localparam int TW = tmr_w(TIMEOUT);
    logic [CNT_W-1:0] cnt_nxt;
    logic [TW-1:0]    tmr;
    always_comb begin
        cnt_nxt  = (inc && !dec) ? cnt + 1'b1 : (dec && !inc && cnt != '0) ? cnt - 1'b1 : cnt;
        room     = cnt_nxt < CNT_W'(MAX);
        zero_nxt = cnt_nxt == '0;
        unexp    = dec && !inc && cnt == '0;
        // single pulse on the edge the timer reaches TIMEOUT; saturation keeps it from re-firing
        tmo      = cnt != '0 && !dec && tmr == TW'(TIMEOUT - 1);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            tmr <= '0;
        end else begin
            cnt <= cnt_nxt;
            tmr <= (cnt == '0 || dec) ? '0 : (tmr == TW'(TIMEOUT)) ? tmr : tmr + 1'b1;
        end
    end
endmodule

// File: rtl/cl_pcim_otr_guard.sv
// cl_pcim_otr_guard: caps outstanding PCIM AXI4 writes/reads, detects hung responses, handles quiesce
module cl_pcim_otr_guard
    import cl_pcim_pkg::*;
#(
    parameter int MAX_WR_OUT = 16,
    parameter int MAX_RD_OUT = 16,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic         aclk,
    input  logic         sync_rst,
    input  logic [15:0]  s_pcim_awid,
    input  logic [63:0]  s_pcim_awaddr,
    input  logic [7:0]   s_pcim_awlen,
    input  logic [2:0]   s_pcim_awsize,
    input  logic         s_pcim_awvalid,
    output logic         s_pcim_awready,
    input  logic [511:0] s_pcim_wdata,
    input  logic [63:0]  s_pcim_wstrb,
    input  logic         s_pcim_wlast,
    input  logic         s_pcim_wvalid,
    output logic         s_pcim_wready,
    output logic [15:0]  s_pcim_bid,
    output logic [1:0]   s_pcim_bresp,
    output logic         s_pcim_bvalid,
    input  logic         s_pcim_bready,
    input  logic [15:0]  s_pcim_arid,
    input  logic [63:0]  s_pcim_araddr,
    input  logic [7:0]   s_pcim_arlen,
    input  logic [2:0]   s_pcim_arsize,
    input  logic         s_pcim_arvalid,
    output logic         s_pcim_arready,
    output logic [15:0]  s_pcim_rid,
    output logic [511:0] s_pcim_rdata,
    output logic [1:0]   s_pcim_rresp,
    output logic         s_pcim_rlast,
    output logic         s_pcim_rvalid,
    input  logic         s_pcim_rready,
    output logic [15:0]  m_pcim_awid,
    output logic [63:0]  m_pcim_awaddr,
    output logic [7:0]   m_pcim_awlen,
    output logic [2:0]   m_pcim_awsize,
    output logic         m_pcim_awvalid,
    input  logic         m_pcim_awready,
    output logic [511:0] m_pcim_wdata,
    output logic [63:0]  m_pcim_wstrb,
    output logic         m_pcim_wlast,
    output logic         m_pcim_wvalid,
    input  logic         m_pcim_wready,
    input  logic [15:0]  m_pcim_bid,
    input  logic [1:0]   m_pcim_bresp,
    input  logic         m_pcim_bvalid,
    output logic         m_pcim_bready,
    output logic [15:0]  m_pcim_arid,
    output logic [63:0]  m_pcim_araddr,
    output logic [7:0]   m_pcim_arlen,
    output logic [2:0]   m_pcim_arsize,
    output logic         m_pcim_arvalid,
    input  logic         m_pcim_arready,
    input  logic [15:0]  m_pcim_rid,
    input  logic [511:0] m_pcim_rdata,
    input  logic [1:0]   m_pcim_rresp,
    input  logic         m_pcim_rlast,
    input  logic         m_pcim_rvalid,
    output logic         m_pcim_rready,
    input  logic         quiesce_req,
    output logic         quiesce_ack,
    input  logic         clr_err,
    output logic [7:0]   wr_out_cnt,
    output logic [7:0]   rd_out_cnt,
    output logic         err_wr_tmo,
    output logic         err_rd_tmo,
    output logic         err_unexp
);
    otr_state_e state, state_nxt;
    logic allow_aw, allow_ar, allow_aw_nxt, allow_ar_nxt;
    logic aw_hs, ar_hs, b_hs, rl_hs;
    logic wr_room, rd_room, wr_zero, rd_zero, wr_tmo, rd_tmo, wr_unexp, rd_unexp;
    assign m_pcim_awid    = s_pcim_awid;
    assign m_pcim_awaddr  = s_pcim_awaddr;
    assign m_pcim_awlen   = s_pcim_awlen;
    assign m_pcim_awsize  = s_pcim_awsize;
    assign m_pcim_awvalid = s_pcim_awvalid & allow_aw;
    assign s_pcim_awready = m_pcim_awready & allow_aw;
    assign m_pcim_wdata   = s_pcim_wdata;
    assign m_pcim_wstrb   = s_pcim_wstrb;
    assign m_pcim_wlast   = s_pcim_wlast;
    assign m_pcim_wvalid  = s_pcim_wvalid;
    assign s_pcim_wready  = m_pcim_wready;
    assign s_pcim_bid     = m_pcim_bid;
    assign s_pcim_bresp   = m_pcim_bresp;
    assign s_pcim_bvalid  = m_pcim_bvalid;
    assign m_pcim_bready  = s_pcim_bready;
    assign m_pcim_arid    = s_pcim_arid;
    assign m_pcim_araddr  = s_pcim_araddr;
    assign m_pcim_arlen   = s_pcim_arlen;
    assign m_pcim_arsize  = s_pcim_arsize;
    assign m_pcim_arvalid = s_pcim_arvalid & allow_ar;
    assign s_pcim_arready = m_pcim_arready & allow_ar;
    assign s_pcim_rid     = m_pcim_rid;
    assign s_pcim_rdata   = m_pcim_rdata;
    assign s_pcim_rresp   = m_pcim_rresp;
    assign s_pcim_rlast   = m_pcim_rlast;
    assign s_pcim_rvalid  = m_pcim_rvalid;
    assign m_pcim_rready  = s_pcim_rready;
    assign aw_hs = s_pcim_awvalid & allow_aw & m_pcim_awready;
    assign ar_hs = s_pcim_arvalid & allow_ar & m_pcim_arready;
    assign b_hs  = m_pcim_bvalid & s_pcim_bready;
    assign rl_hs = m_pcim_rvalid & s_pcim_rready & m_pcim_rlast;
    assign quiesce_ack = state == QUIESCED;
    cl_pcim_otr_ctr #(.MAX(MAX_WR_OUT), .TIMEOUT(TIMEOUT_CYC)) u_wr (
        .clk(aclk), .rst(sync_rst), .inc(aw_hs), .dec(b_hs), .cnt(wr_out_cnt),
        .room(wr_room), .zero_nxt(wr_zero), .tmo(wr_tmo), .unexp(wr_unexp)
    );
    cl_pcim_otr_ctr #(.MAX(MAX_RD_OUT), .TIMEOUT(TIMEOUT_CYC)) u_rd (
        .clk(aclk), .rst(sync_rst), .inc(ar_hs), .dec(rl_hs), .cnt(rd_out_cnt),
        .room(rd_room), .zero_nxt(rd_zero), .tmo(rd_tmo), .unexp(rd_unexp)
    );
    always_comb begin
        state_nxt = state;
        case (state)
            RUN:      state_nxt = quiesce_req ? DRAIN : RUN;
            DRAIN:    state_nxt = !quiesce_req ? RUN : (wr_zero && rd_zero) ? QUIESCED : DRAIN;
            QUIESCED: state_nxt = quiesce_req ? QUIESCED : RUN;
            HUNG:     state_nxt = !clr_err ? HUNG : quiesce_req ? DRAIN : RUN;
            default:  state_nxt = RUN;
        endcase
        if (wr_tmo || rd_tmo) state_nxt = HUNG;
        // a presented but unaccepted request keeps its gate open so valid is never withdrawn
        allow_aw_nxt = (state_nxt == RUN && wr_room) || (allow_aw && s_pcim_awvalid && !m_pcim_awready);
        allow_ar_nxt = (state_nxt == RUN && rd_room) || (allow_ar && s_pcim_arvalid && !m_pcim_arready);
    end
    always_ff @(posedge aclk) begin
        if (sync_rst) begin
            state      <= RUN;
            allow_aw   <= 1'b1;
            allow_ar   <= 1'b1;
            err_wr_tmo <= 1'b0;
            err_rd_tmo <= 1'b0;
            err_unexp  <= 1'b0;
        end else begin
            state      <= state_nxt;
            allow_aw   <= allow_aw_nxt;
            allow_ar   <= allow_ar_nxt;
            err_wr_tmo <= wr_tmo || (err_wr_tmo && !clr_err);
            err_rd_tmo <= rd_tmo || (err_rd_tmo && !clr_err);
            err_unexp  <= wr_unexp || rd_unexp || (err_unexp && !clr_err);
        end
    end
endmodule
